// File: rtl/alu_pkg.sv
// Shared opcode constants, flag bit positions, FSM states and flag packing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_SBC = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-step shifter: holds data, remaining count, direction and arithmetic mode.
// Latency: one bit per cycle while step is high; step_data/step_carry show the next step combinationally.
// Backpressure: none; the owner controls progress through load/step.
// Ports: clk, rst (sync, active-high); load + load_* capture a new job; step advances one bit;
//        count = bits still to shift; step_data/step_carry = value and bit shifted out on the next step.
module alu_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [SHIFT_W-1:0]    load_amt,
    input  logic                  load_right,
    input  logic                  load_arith,
    output logic [SHIFT_W-1:0]    count,
    output logic [DATA_WIDTH-1:0] step_data,
    output logic                  step_carry
);

    logic [DATA_WIDTH-1:0] data_q;
    logic                  right_q;
    logic                  arith_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            count   <= '0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
        end else if (load) begin
            data_q  <= load_data;
            count   <= load_amt;
            right_q <= load_right;
            arith_q <= load_arith;
        end else if (step && (count != '0)) begin
            data_q <= step_data;
            count  <= count - SHIFT_W'(1);
        end
    end

    // Right shifts fill with the MSB only in arithmetic mode.
    always_comb begin
        step_data  = {data_q[DATA_WIDTH-2:0], 1'b0};
        step_carry = data_q[DATA_WIDTH-1];
        if (right_q) begin
            step_data  = {arith_q & data_q[DATA_WIDTH-1], data_q[DATA_WIDTH-1:1]};
            step_carry = data_q[0];
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops, iterative shifts, registered result and NZCV flags.
// Latency: 1 cycle for non-shift and zero-amount shifts; n+1 cycles for a shift by n>0.
// Backpressure: result/flag hold while out_valid & ~out_ready; in_ready drops when busy or result undrained.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with aluop, op_a, op_b, flag_we;
//        out_valid/out_ready with result, flag {N,Z,C,V}; busy high during shift iterations.
module seq_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            aluop,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic                  flag_we,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [3:0]            flag,
    output logic                  busy
);
    import alu_pkg::*;

    state_t                state, state_nxt;
    logic                  accept, start_shift, fin_shift, flag_we_q;
    logic [SHIFT_W-1:0]    amt, sh_count;
    logic [DATA_WIDTH-1:0] sh_data, alu_res;
    logic                  sh_carry, alu_c, alu_v, alu_arith, alu_sub, cin;
    logic [DATA_WIDTH:0]   ext;
    logic [3:0]            alu_flags, sh_flags;

    // Gated by rst so nothing is accepted in the reset cycle.
    assign in_ready    = ~rst & (state == ST_IDLE) & (~out_valid | out_ready);
    assign busy        = (state == ST_SHIFT);
    assign accept      = in_valid & in_ready;
    assign amt         = op_b[SHIFT_W-1:0];
    assign start_shift = accept & is_shift_op(aluop) & (amt != '0);
    // The last step lands directly in the result register, so done is count==1, not 0.
    assign fin_shift   = busy & (sh_count == SHIFT_W'(1));
    assign cin         = flag[FLAG_C];

    alu_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_W    (SHIFT_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (start_shift),
        .step       (busy),
        .load_data  (op_a),
        .load_amt   (amt),
        .load_right (aluop != OP_SLL),
        .load_arith (aluop == OP_SRA),
        .count      (sh_count),
        .step_data  (sh_data),
        .step_carry (sh_carry)
    );

    // Single-cycle datapath; shift opcodes here only cover the zero-amount case.
    always_comb begin
        ext       = '0;
        alu_res   = op_b;
        alu_c     = 1'b0;
        alu_arith = 1'b0;
        alu_sub   = 1'b0;
        case (aluop)
            OP_ADD: begin
                ext       = {1'b0, op_a} + {1'b0, op_b};
                alu_arith = 1'b1;
            end
            OP_SUB: begin
                ext       = {1'b0, op_a} - {1'b0, op_b};
                alu_arith = 1'b1;
                alu_sub   = 1'b1;
            end
            OP_ADC: begin
                ext       = {1'b0, op_a} + {1'b0, op_b} + {{DATA_WIDTH{1'b0}}, cin};
                alu_arith = 1'b1;
            end
            OP_SBC: begin
                ext       = {1'b0, op_a} - {1'b0, op_b} - {{DATA_WIDTH{1'b0}}, cin};
                alu_arith = 1'b1;
                alu_sub   = 1'b1;
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SLL, OP_SRL, OP_SRA: begin
                alu_res = op_a;
                alu_c   = cin;
            end
            default: alu_res = op_b;
        endcase
        if (alu_arith) begin
            alu_res = ext[DATA_WIDTH-1:0];
            alu_c   = ext[DATA_WIDTH];
        end
        alu_v = alu_arith &
                (( alu_res[DATA_WIDTH-1] & ~op_a[DATA_WIDTH-1] & ~(alu_sub ^ op_b[DATA_WIDTH-1])) |
                 (~alu_res[DATA_WIDTH-1] &  op_a[DATA_WIDTH-1] &  (alu_sub ^ op_b[DATA_WIDTH-1])));
        alu_flags = pack_flags(alu_res[DATA_WIDTH-1], alu_res == '0, alu_c, alu_v);
        sh_flags  = pack_flags(sh_data[DATA_WIDTH-1], sh_data == '0, sh_carry, 1'b0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_shift) state_nxt = ST_SHIFT;
            ST_SHIFT: if (fin_shift)   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A shift can only finish with out_valid already low, so the two load paths never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            flag      <= '0;
            out_valid <= 1'b0;
            flag_we_q <= 1'b0;
        end else begin
            if (fin_shift) begin
                result    <= sh_data;
                out_valid <= 1'b1;
                if (flag_we_q) flag <= sh_flags;
            end else if (accept && !start_shift) begin
                result    <= alu_res;
                out_valid <= 1'b1;
                if (flag_we) flag <= alu_flags;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (start_shift) flag_we_q <= flag_we;
        end
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width; legal range 8..64.
REQ-002 Parameter: SHIFT_W, default $clog2(DATA_WIDTH), width of the shift-amount field taken from op_b.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 in_valid  in  1  operation request valid.
REQ-006 in_ready  out  1  block accepts the request this cycle.
REQ-007 aluop  in  4  opcode.
REQ-008 op_a  in  DATA_WIDTH  operand A.
REQ-009 op_b  in  DATA_WIDTH  operand B; low SHIFT_W bits are the shift amount for shift ops.
REQ-010 flag_we  in  1  the accepted op updates the flag register on completion.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer takes the result.
REQ-013 result  out  DATA_WIDTH  registered result.
REQ-014 flag  out  4  registered flags {N,Z,C,V}.
REQ-015 busy  out  1  high while a shift is iterating.

Function
REQ-016 Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, ADC=5, SBC=6, SLL=7, SRL=8, SRA=9; 10..15 = PASS (result=op_b).
REQ-017 Transfer on in_valid&in_ready; result transfer on out_valid&out_ready.
REQ-018 in_ready = (state==IDLE) & (~out_valid | out_ready); accept and drain in the same cycle are legal.
REQ-019 States IDLE, SHIFT: IDLE->SHIFT on an accepted shift op with amount>0; SHIFT->IDLE when the remaining count reaches 0; all other ops stay in IDLE.
REQ-020 Non-shift ops and zero-amount shifts: latency 1 (out_valid the cycle after acceptance).
REQ-021 Shift by n>0: one bit per cycle; out_valid asserted n+1 cycles after acceptance; busy high for the n SHIFT cycles.
REQ-022 Arithmetic in DATA_WIDTH+1 bits: ADD a+b; SUB a-b; ADC a+b+C; SBC a-b-C; C = bit DATA_WIDTH of the extended result (carry on add, borrow on sub).
REQ-023 V = (R_msb & ~A_msb & ~(s^B_msb)) | (~R_msb & A_msb & (s^B_msb)), with s=1 for SUB/SBC; V=0 for all other ops.
REQ-024 N = result MSB; Z = (result==0), for every op.
REQ-025 Logic ops and PASS: C=0.
REQ-026 Shifts: C = last bit shifted out; zero-amount shift leaves C at its current register value; SRA replicates the MSB.
REQ-027 ADC/SBC use the flag-register C as it stands at acceptance, including when the prior op's flag write lands the same cycle.
REQ-028 Flag register updates only when an op with flag_we=1 completes (loads result); otherwise it holds.
REQ-029 result/flag hold stable while out_valid & ~out_ready.
REQ-030 out_valid clears on drain unless a new result loads the same cycle.
REQ-031 Inputs are ignored while in_ready=0; operands are captured at acceptance.

Reset
REQ-032 rst dominates all other inputs, including during SHIFT: state->IDLE, out_valid=0, busy=0, result=0, flag=4'b0000, shift count=0.
REQ-033 in_ready=0 during the reset cycle and =1 in the first cycle after reset deasserts.

Structure
REQ-034 Opcode constants, flag bit indices (N=3, Z=2, C=1, V=0) and the state enum reside in the shared package alu_pkg.
REQ-035 The iterative one-bit shifter (data, count, direction, arithmetic, carry-out) is the sub-module alu_shifter; everything else is flat in seq_alu.

Verification
REQ-036 DATA_WIDTH=8, ADD 0x7F+0x01, flag_we=1 -> result 0x80 after 1 cycle, flag N=1 Z=0 C=0 V=1.
REQ-037 DATA_WIDTH=8, SUB 0x00-0x01, flag_we=1, then SBC 0x05-0x02 -> first 0xFF with C=1; second 0x02 (5-2-1).
REQ-038 DATA_WIDTH=32, SRA 0x80000000 by 4 -> busy 4 cycles, out_valid at cycle 5, result 0xF8000000, C=0, N=1.
REQ-039 out_ready held low for 3 cycles after ADD completes -> in_ready=0, result/flag stable; out_ready high -> new op accepted in the same cycle as drain.
REQ-040 rst asserted in the 2nd cycle of an SLL by 7 -> next cycle state IDLE, out_valid=0, busy=0, flag=0, in_ready=1 after release.
REQ-041 XOR 0x55^0x55 with flag_we=0 -> result 0x00, flag unchanged from the previous value.
